// File: rtl/intraloop_pkg.sv
// Shared types and constants for the intra-loop sequencer.
//   state_e      : sequencer FSM states
//   ENABLER_*    : one-hot reconstructor stage enables ([0] extract, [1] predict, [2] save)
//   luma_index() : raster index of a 4x4 luma block from MB coordinates and sub-block number
package intraloop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExtract,
    StPredict,
    StSave,
    StWaitFb
  } state_e;

  localparam logic [2:0] ENABLER_NONE    = 3'b000;
  localparam logic [2:0] ENABLER_EXTRACT = 3'b001;
  localparam logic [2:0] ENABLER_PREDICT = 3'b010;
  localparam logic [2:0] ENABLER_SAVE    = 3'b100;

  localparam int unsigned SUBBLK_PER_MB = 16;

  // Sub-block k sits at row k/4, column k%4 inside the MB; a luma row holds width/4 blocks.
  function automatic logic [31:0] luma_index(input logic [31:0] mx, input logic [31:0] my,
                                             input logic [3:0] k, input logic [31:0] width);
    return ((my << 2) + {30'd0, k[3:2]}) * (width >> 2) + (mx << 2) + {30'd0, k[1:0]};
  endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Macroblock raster address generator.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : zero all counters (start of frame)
//   advance_i      : step to the next 4x4 sub-block, wrapping MB and frame
//   luma_o         : registered raster index of the current 4x4 luma block
//   chroma_o       : registered MB index (index of the co-sited 8x8 Cb/Cr block)
//   last_o         : registered flag, current sub-block is the last of the frame
module mb_addr_gen
  import intraloop_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned LENGTH = 720
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        advance_i,
  output logic [31:0] luma_o,
  output logic [31:0] chroma_o,
  output logic        last_o
);

  localparam logic [31:0] MBW   = 32'(WIDTH / 16);
  localparam logic [31:0] MBH   = 32'(LENGTH / 16);
  localparam logic [3:0]  KLAST = 4'(SUBBLK_PER_MB - 1);

  logic [3:0]  k_q, k_d;
  logic [31:0] mx_q, mx_d, my_q, my_d;
  logic [31:0] luma_q, luma_d, chroma_q, chroma_d;
  logic        last_q, last_d;

  always_comb begin
    k_d  = k_q;
    mx_d = mx_q;
    my_d = my_q;
    if (clear_i) begin
      k_d  = '0;
      mx_d = '0;
      my_d = '0;
    end else if (advance_i) begin
      if (k_q == KLAST) begin
        k_d = '0;
        if (mx_q == MBW - 1) begin
          mx_d = '0;
          my_d = (my_q == MBH - 1) ? '0 : my_q + 1;
        end else begin
          mx_d = mx_q + 1;
        end
      end else begin
        k_d = k_q + 4'd1;
      end
    end
    luma_d   = luma_index(mx_d, my_d, k_d, 32'(WIDTH));
    chroma_d = my_d * MBW + mx_d;
    last_d   = (k_d == KLAST) && (mx_d == MBW - 1) && (my_d == MBH - 1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k_q      <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      luma_q   <= '0;
      chroma_q <= '0;
      last_q   <= 1'b0;
    end else begin
      k_q      <= k_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      luma_q   <= luma_d;
      chroma_q <= chroma_d;
      last_q   <= last_d;
    end
  end

  assign luma_o   = luma_q;
  assign chroma_o = chroma_q;
  assign last_o   = last_q;

endmodule

// File: rtl/intraloop_sequencer.sv
// Intra-loop sequencer: accepts one residue block per handshake and drives the intra
// reconstructor through extract -> predict -> save, then waits for saver feedback.
//   clk, reset                       : clock, synchronous active-high reset
//   frame_start                      : zero the MB/sub-block counters (IDLE only)
//   blk_valid / blk_ready            : upstream pass handshake
//   fb_luma4x4/chromab8x8/chromar8x8 : saver write-back done strobes
//   enabler                          : one-hot stage enable to the reconstructor
//   mbnumber_*                       : current block indices, stable for the whole pass
//   blk_done, frame_done, err_timeout: single-cycle status pulses
module intraloop_sequencer
  import intraloop_pkg::*;
#(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned LENGTH      = 720,
  parameter int unsigned EXT_CYCLES  = 1,
  parameter int unsigned PRED_CYCLES = 1,
  parameter int unsigned FB_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        fb_luma4x4,
  input  logic        fb_chromab8x8,
  input  logic        fb_chromar8x8,
  output logic [2:0]  enabler,
  output logic [31:0] mbnumber_luma4x4,
  output logic [31:0] mbnumber_chromab8x8,
  output logic [31:0] mbnumber_chromar8x8,
  output logic        blk_done,
  output logic        frame_done,
  output logic        err_timeout
);

  state_e     state_q, state_d;
  logic [3:0] stage_cnt_q, stage_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fb_l_q, fb_l_d, fb_b_q, fb_b_d, fb_r_q, fb_r_d;
  logic [2:0] enabler_q, enabler_d;
  logic       blk_ready_q, blk_ready_d;
  logic       blk_done_q, blk_done_d;
  logic       frame_done_q, frame_done_d;
  logic       err_q, err_d;
  logic       clear, advance, last_blk, all_fb, timeout;
  logic [31:0] chroma_idx;

  mb_addr_gen #(
    .WIDTH (WIDTH),
    .LENGTH(LENGTH)
  ) u_addr (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (clear),
    .advance_i(advance),
    .luma_o   (mbnumber_luma4x4),
    .chroma_o (chroma_idx),
    .last_o   (last_blk)
  );

  // Status pulses are registered, so they are decided one cycle early from the
  // feedback latches as they will be after this edge.
  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fb_l_d      = fb_l_q;
    fb_b_d      = fb_b_q;
    fb_r_d      = fb_r_q;
    blk_done_d  = 1'b0;
    err_d       = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    all_fb      = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      StIdle: begin
        clear = frame_start;
        if (blk_valid) begin
          state_d     = StExtract;
          stage_cnt_d = '0;
        end
      end
      StExtract: begin
        if (stage_cnt_q == 4'(EXT_CYCLES - 1)) begin
          state_d     = StPredict;
          stage_cnt_d = '0;
        end else begin
          stage_cnt_d = stage_cnt_q + 4'd1;
        end
      end
      StPredict: begin
        if (stage_cnt_q == 4'(PRED_CYCLES - 1)) begin
          state_d     = StSave;
          stage_cnt_d = '0;
        end else begin
          stage_cnt_d = stage_cnt_q + 4'd1;
        end
      end
      StSave, StWaitFb: begin
        if (state_q == StWaitFb && blk_done_q) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
          fb_l_d     = 1'b0;
          fb_b_d     = 1'b0;
          fb_r_d     = 1'b0;
          advance    = 1'b1;
        end else begin
          state_d    = StWaitFb;
          fb_l_d     = fb_l_q | fb_luma4x4;
          fb_b_d     = fb_b_q | fb_chromab8x8;
          fb_r_d     = fb_r_q | fb_chromar8x8;
          // wait_cnt holds the 1-based number of the current WAIT_FB cycle.
          wait_cnt_d = (state_q == StSave) ? 8'd1 : wait_cnt_q + 8'd1;
          all_fb     = fb_l_d & fb_b_d & fb_r_d;
          timeout    = (wait_cnt_d == 8'(FB_TIMEOUT));
          blk_done_d = all_fb | timeout;
          err_d      = timeout & ~all_fb;
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StExtract: enabler_d = ENABLER_EXTRACT;
      StPredict: enabler_d = ENABLER_PREDICT;
      StSave:    enabler_d = ENABLER_SAVE;
      default:   enabler_d = ENABLER_NONE;
    endcase
    blk_ready_d  = (state_d == StIdle);
    frame_done_d = blk_done_d & last_blk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      stage_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      fb_l_q       <= 1'b0;
      fb_b_q       <= 1'b0;
      fb_r_q       <= 1'b0;
      enabler_q    <= ENABLER_NONE;
      blk_ready_q  <= 1'b1;
      blk_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_cnt_q  <= stage_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      fb_l_q       <= fb_l_d;
      fb_b_q       <= fb_b_d;
      fb_r_q       <= fb_r_d;
      enabler_q    <= enabler_d;
      blk_ready_q  <= blk_ready_d;
      blk_done_q   <= blk_done_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign enabler             = enabler_q;
  assign blk_ready           = blk_ready_q;
  assign blk_done            = blk_done_q;
  assign frame_done          = frame_done_q;
  assign err_timeout         = err_q;
  assign mbnumber_chromab8x8 = chroma_idx;
  assign mbnumber_chromar8x8 = chroma_idx;

endmodule

// File: tb/tb_intraloop_sequencer.sv
// Directed bench for intraloop_sequencer. Two instances share all inputs: u_dut at
// 1280x720 and u_small at 32x32 (4 MBs per frame); both use FB_TIMEOUT=8.
module tb_intraloop_sequencer;

  logic        clk = 1'b0;
  logic        reset, frame_start, blk_valid;
  logic        fb_luma4x4, fb_chromab8x8, fb_chromar8x8;
  logic        blk_ready, blk_done, frame_done, err_timeout;
  logic [2:0]  enabler;
  logic [31:0] luma, chroma_b, chroma_r;
  logic        blk_ready_s, blk_done_s, frame_done_s, err_timeout_s;
  logic [2:0]  enabler_s;
  logic [31:0] luma_s, chroma_b_s, chroma_r_s;

  int n_checks = 0;
  int n_errors = 0;

  // Values captured by run_pass
  logic [2:0]  en_log [0:7];
  int          lat;
  logic [31:0] cap_luma, cap_cb, cap_cr, cap_luma_s, cap_cb_s;
  logic        cap_ready, cap_fd, cap_fd_s, cap_err;

  always #5 clk = ~clk;

  intraloop_sequencer #(
    .WIDTH(1280), .LENGTH(720), .EXT_CYCLES(1), .PRED_CYCLES(1), .FB_TIMEOUT(8)
  ) u_dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .fb_luma4x4(fb_luma4x4), .fb_chromab8x8(fb_chromab8x8),
    .fb_chromar8x8(fb_chromar8x8), .enabler(enabler), .mbnumber_luma4x4(luma),
    .mbnumber_chromab8x8(chroma_b), .mbnumber_chromar8x8(chroma_r), .blk_done(blk_done),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  intraloop_sequencer #(
    .WIDTH(32), .LENGTH(32), .EXT_CYCLES(1), .PRED_CYCLES(1), .FB_TIMEOUT(8)
  ) u_small (
    .clk(clk), .reset(reset), .frame_start(frame_start), .blk_valid(blk_valid),
    .blk_ready(blk_ready_s), .fb_luma4x4(fb_luma4x4), .fb_chromab8x8(fb_chromab8x8),
    .fb_chromar8x8(fb_chromar8x8), .enabler(enabler_s), .mbnumber_luma4x4(luma_s),
    .mbnumber_chromab8x8(chroma_b_s), .mbnumber_chromar8x8(chroma_r_s),
    .blk_done(blk_done_s), .frame_done(frame_done_s), .err_timeout(err_timeout_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    blk_valid   = 1'b0;
    frame_start = 1'b0;
    fb_luma4x4 = 1'b0; fb_chromab8x8 = 1'b0; fb_chromar8x8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One pass; feedback strobes at d_* cycles after the SAVE cycle (negative = never).
  // fs_accept drives frame_start with the accept, fs_at drives it in pass cycle fs_at.
  // lat is the cycle (relative to accept) where blk_done was seen.
  task automatic run_pass(input int d_l, input int d_b, input int d_r,
                          input logic fs_accept, input int fs_at);
    int c;
    bit done;
    @(negedge clk);
    check_eq("ready_in_idle", {31'd0, blk_ready}, 32'd1);
    blk_valid   = 1'b1;
    frame_start = fs_accept;
    c = 0;
    done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      blk_valid   = 1'b0;
      frame_start = (c == fs_at);
      if (c < 8) en_log[c] = enabler;
      if (c == 1) begin
        cap_luma = luma; cap_cb = chroma_b; cap_cr = chroma_r;
        cap_luma_s = luma_s; cap_cb_s = chroma_b_s;
      end
      if (c == 2) cap_ready = blk_ready;
      if (blk_done) begin
        done = 1; lat = c;
        cap_fd = frame_done; cap_fd_s = frame_done_s; cap_err = err_timeout;
      end
      fb_luma4x4    = (d_l >= 0) && (c == 3 + d_l);
      fb_chromab8x8 = (d_b >= 0) && (c == 3 + d_b);
      fb_chromar8x8 = (d_r >= 0) && (c == 3 + d_r);
    end
    fb_luma4x4 = 1'b0; fb_chromab8x8 = 1'b0; fb_chromar8x8 = 1'b0;
    frame_start = 1'b0;
    if (!done) begin
      check_eq("blk_done_seen", 32'd0, 32'd1);
      lat = -1;
    end
  endtask

  logic [31:0] exp_luma2 [0:16] = '{0, 1, 2, 3, 320, 321, 322, 323, 640, 641, 642, 643,
                                    960, 961, 962, 963, 4};

  initial begin
    // 1: reset state and a single pass
    do_reset();
    check_eq("rst_enabler", {29'd0, enabler}, 32'd0);
    check_eq("rst_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("rst_luma", luma, 32'd0);
    check_eq("rst_chroma", chroma_b, 32'd0);
    check_eq("rst_pulses", {29'd0, blk_done, frame_done, err_timeout}, 32'd0);
    run_pass(0, 0, 0, 1'b0, -1);
    check_eq("t1_en_extract", {29'd0, en_log[1]}, 32'd1);
    check_eq("t1_en_predict", {29'd0, en_log[2]}, 32'd2);
    check_eq("t1_en_save", {29'd0, en_log[3]}, 32'd4);
    check_eq("t1_en_wait", {29'd0, en_log[4]}, 32'd0);
    check_eq("t1_ready_busy", {31'd0, cap_ready}, 32'd0);
    check_eq("t1_latency", 32'(lat), 32'd4);
    check_eq("t1_luma", cap_luma, 32'd0);
    check_eq("t1_chroma", cap_cb, 32'd0);
    check_eq("t1_err", {31'd0, cap_err}, 32'd0);

    // 2: 17 back-to-back passes through the raster order
    do_reset();
    for (int p = 0; p < 17; p++) begin
      run_pass(0, 0, 0, 1'b0, -1);
      check_eq($sformatf("t2_luma[%0d]", p), cap_luma, exp_luma2[p]);
      check_eq($sformatf("t2_cb[%0d]", p), cap_cb, (p < 16) ? 32'd0 : 32'd1);
      check_eq($sformatf("t2_cr[%0d]", p), cap_cr, (p < 16) ? 32'd0 : 32'd1);
      check_eq($sformatf("t2_lat[%0d]", p), 32'(lat), 32'd4);
    end
    // frame_start outside IDLE is ignored; with the accept it restarts at index 0
    run_pass(0, 0, 0, 1'b0, 2);
    check_eq("fs_busy_luma", cap_luma, 32'd5);
    run_pass(0, 0, 0, 1'b0, -1);
    check_eq("fs_busy_next", cap_luma, 32'd6);
    run_pass(0, 0, 0, 1'b1, -1);
    check_eq("fs_idle_luma", cap_luma, 32'd0);
    check_eq("fs_idle_chroma", cap_cb, 32'd0);
    run_pass(0, 0, 0, 1'b0, -1);
    check_eq("fs_idle_next", cap_luma, 32'd1);

    // 4: Cr feedback withheld -> timeout in the 8th WAIT_FB cycle, index still advances
    do_reset();
    run_pass(0, 0, -1, 1'b0, -1);
    check_eq("t4_latency", 32'(lat), 32'd11);
    check_eq("t4_err", {31'd0, cap_err}, 32'd1);
    // 5: staggered feedback -> done the cycle after Cr
    run_pass(0, 2, 5, 1'b0, -1);
    check_eq("t5_luma_after_timeout", cap_luma, 32'd1);
    check_eq("t5_latency", 32'(lat), 32'd9);
    check_eq("t5_err", {31'd0, cap_err}, 32'd0);

    // 6: reset during PREDICT aborts the pass
    do_reset();
    @(negedge clk);
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_in_predict", {29'd0, enabler}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_enabler", {29'd0, enabler}, 32'd0);
    check_eq("t6_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("t6_luma", luma, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t6_no_done[%0d]", i), {31'd0, blk_done}, 32'd0);
      @(negedge clk);
    end
    run_pass(0, 0, 0, 1'b0, -1);
    check_eq("t6_next_luma", cap_luma, 32'd0);
    check_eq("t6_next_latency", 32'(lat), 32'd4);

    // 3: 32x32 frame of 64 passes, frame_done only on the last
    do_reset();
    for (int p = 0; p < 65; p++) begin
      int m, k, exp_l;
      m = (p % 64) / 16;
      k = p % 16;
      exp_l = (4 * (m / 2) + k / 4) * 8 + 4 * (m % 2) + k % 4;
      run_pass(0, 0, 0, 1'b0, -1);
      check_eq($sformatf("t3_luma[%0d]", p), cap_luma_s, 32'(exp_l));
      check_eq($sformatf("t3_chroma[%0d]", p), cap_cb_s, 32'(m));
      check_eq($sformatf("t3_fd[%0d]", p), {31'd0, cap_fd_s}, (p == 63) ? 32'd1 : 32'd0);
      if (p == 63) check_eq("t3_big_fd", {31'd0, cap_fd}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
